// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the two-requester Avalon-MM SDRAM arbiter.
package avalon_arb_pkg;

    // Transaction phases of the shared host port
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_CMD   = 2'd1,
        RD_DATA  = 2'd2,
        WR_BURST = 2'd3
    } arb_state_t;

    // Requester indices: video reader and auxiliary master
    localparam int REQ_VIDEO = 0;
    localparam int REQ_AUX   = 1;
    localparam int NUM_REQ   = 2;

    // Default Avalon widths
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int DEF_BW = 6;

endpackage

// File: rtl/avalon_arbiter_rr.sv
// Two-way round-robin pick: the requester that did not win last time gets
// priority when both are asking.
module rr_arbiter2
    import avalon_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,       // index of the most recent winner
    output logic [1:0] grant_next  // one-hot winner, 2'b00 when nobody asks
);

    // Resolve contention against the last winner; otherwise pass the lone request
    always_comb begin
        grant_next = 2'b00;
        if (req == 2'b11) begin
            if (last) grant_next[REQ_VIDEO] = 1'b1;
            else      grant_next[REQ_AUX]   = 1'b1;
        end else begin
            grant_next = req;
        end
    end

endmodule

// File: rtl/avalon_arbiter.sv
// Arbitrates a video reader and an auxiliary master onto one SDRAM Avalon-MM
// host port. One burst in flight at a time; the owner's command passes
// straight through, read data is steered back to the owner only.
module avalon_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int BW = DEF_BW
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic [AW-1:0]   m0_address,
    input  logic [BW-1:0]   m0_burstcount,
    input  logic [DW-1:0]   m0_writedata,
    input  logic [DW/8-1:0] m0_byteenable,
    input  logic            m0_read,
    input  logic            m0_write,
    output logic            m0_waitrequest,
    output logic [DW-1:0]   m0_readdata,
    output logic            m0_readdatavalid,

    input  logic [AW-1:0]   m1_address,
    input  logic [BW-1:0]   m1_burstcount,
    input  logic [DW-1:0]   m1_writedata,
    input  logic [DW/8-1:0] m1_byteenable,
    input  logic            m1_read,
    input  logic            m1_write,
    output logic            m1_waitrequest,
    output logic [DW-1:0]   m1_readdata,
    output logic            m1_readdatavalid,

    output logic [AW-1:0]   s_address,
    output logic [BW-1:0]   s_burstcount,
    output logic [DW-1:0]   s_writedata,
    output logic [DW/8-1:0] s_byteenable,
    output logic            s_read,
    output logic            s_write,
    input  logic            s_waitrequest,
    input  logic [DW-1:0]   s_readdata,
    input  logic            s_readdatavalid,

    output logic [1:0]      grant,
    output logic            err_stray
);

    localparam int BEW = DW / 8;
    localparam logic [BW-1:0] BEAT_ONE = BW'(1);

    logic [NUM_REQ-1:0][AW-1:0]  m_address;
    logic [NUM_REQ-1:0][BW-1:0]  m_burstcount;
    logic [NUM_REQ-1:0][DW-1:0]  m_writedata;
    logic [NUM_REQ-1:0][BEW-1:0] m_byteenable;
    logic [NUM_REQ-1:0]          m_read, m_write, req;
    logic [NUM_REQ-1:0]          m_waitreq, m_rdv;

    arb_state_t    state, state_nxt;
    logic [1:0]    grant_q, grant_nxt, rr_grant;
    logic          last_q, last_nxt;
    logic [BW-1:0] beat_cnt, beat_cnt_nxt;
    logic [BW-1:0] beat_tot, beat_tot_nxt;
    logic [BW-1:0] beat_inc, own_burst, wr_tot;
    logic          own;

    assign m_address    = {m1_address,    m0_address};
    assign m_burstcount = {m1_burstcount, m0_burstcount};
    assign m_writedata  = {m1_writedata,  m0_writedata};
    assign m_byteenable = {m1_byteenable, m0_byteenable};
    assign m_read       = {m1_read,  m0_read};
    assign m_write      = {m1_write, m0_write};
    assign req          = m_read | m_write;

    rr_arbiter2 u_rr (
        .req        (req),
        .last       (last_q),
        .grant_next (rr_grant)
    );

    // Owner index; grant is one-hot whenever the FSM is outside IDLE
    assign own       = grant_q[REQ_AUX];
    // A burstcount of 0 is treated as a single beat
    assign own_burst = (m_burstcount[own] == '0) ? BEAT_ONE : m_burstcount[own];
    // The write length is only known once the first beat is accepted
    assign wr_tot    = (beat_cnt == '0) ? own_burst : beat_tot;
    // Max burst is 2^(BW-1), so this never wraps
    assign beat_inc  = beat_cnt + BEAT_ONE;

    // Command pass-through, waitrequest steering and read-data routing
    always_comb begin
        s_address    = m_address[own];
        s_burstcount = m_burstcount[own];
        s_writedata  = m_writedata[own];
        s_byteenable = m_byteenable[own];
        s_read       = 1'b0;
        s_write      = 1'b0;
        m_waitreq    = '1;
        m_rdv        = '0;
        err_stray    = 1'b0;
        case (state)
            RD_CMD: begin
                s_read         = m_read[own];
                m_waitreq[own] = s_waitrequest;
            end
            WR_BURST: begin
                s_write        = m_write[own];
                m_waitreq[own] = s_waitrequest;
            end
            RD_DATA: m_rdv[own] = s_readdatavalid;
            default: ;
        endcase
        // Any return beat outside a read data phase has no home
        if (state != RD_DATA) err_stray = s_readdatavalid;
    end

    // Next-state: grant on request, count beats, release to IDLE on the last one
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant_q;
        last_nxt     = last_q;
        beat_cnt_nxt = beat_cnt;
        beat_tot_nxt = beat_tot;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_nxt    = rr_grant;
                    last_nxt     = rr_grant[REQ_AUX];
                    beat_cnt_nxt = '0;
                    // Read wins when the winner raises both strobes
                    state_nxt    = m_read[rr_grant[REQ_AUX]] ? RD_CMD : WR_BURST;
                end
            end
            RD_CMD: begin
                if (s_read && !s_waitrequest) begin
                    beat_tot_nxt = own_burst;
                    beat_cnt_nxt = '0;
                    state_nxt    = RD_DATA;
                end
            end
            RD_DATA: begin
                if (s_readdatavalid) begin
                    beat_cnt_nxt = beat_inc;
                    if (beat_inc == beat_tot) begin
                        state_nxt    = IDLE;
                        grant_nxt    = '0;
                        beat_cnt_nxt = '0;
                    end
                end
            end
            WR_BURST: begin
                if (s_write && !s_waitrequest) begin
                    if (beat_cnt == '0) beat_tot_nxt = own_burst;
                    beat_cnt_nxt = beat_inc;
                    // Leaving here drops grant, so the owner sees waitrequest=1
                    // from the cycle after its last accepted beat
                    if (beat_inc == wr_tot) begin
                        state_nxt    = IDLE;
                        grant_nxt    = '0;
                        beat_cnt_nxt = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State registers; last_q=1 after reset so requester 0 wins first
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant_q  <= '0;
            last_q   <= 1'b1;
            beat_cnt <= '0;
            beat_tot <= '0;
        end else begin
            state    <= state_nxt;
            grant_q  <= grant_nxt;
            last_q   <= last_nxt;
            beat_cnt <= beat_cnt_nxt;
            beat_tot <= beat_tot_nxt;
        end
    end

    assign grant            = grant_q;
    assign m0_waitrequest   = m_waitreq[REQ_VIDEO];
    assign m1_waitrequest   = m_waitreq[REQ_AUX];
    assign m0_readdatavalid = m_rdv[REQ_VIDEO];
    assign m1_readdatavalid = m_rdv[REQ_AUX];
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

endmodule

// File: tb/tb_avalon_arbiter.sv
// Directed bench for avalon_arbiter with a transaction-level reference model
// compared on every falling edge, plus literal checkpoints per scenario.
module tb_avalon_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] m0_address, m1_address, s_address;
    logic [5:0]  m0_burstcount, m1_burstcount, s_burstcount;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [1:0]  grant;
    logic        err_stray;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;
    int cnt_rdv0 = 0, cnt_rdv1 = 0, cnt_err = 0, cnt_wr_acc = 0;

    // Reference model: who owns the port and how much of the burst remains
    int md_owner = -1;
    int md_last = 1;
    bit md_rd = 0, md_cmd_done = 0, md_first = 1;
    int md_left = 0;

    always #5 clk = ~clk;

    avalon_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_burstcount(m1_burstcount),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_burstcount(s_burstcount),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .grant(grant), .err_stray(err_stray)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int norm_bc(input logic [5:0] b);
        return (b == 6'd0) ? 1 : int'(b);
    endfunction

    // Model update from the inputs present at the rising edge
    always @(posedge clk) begin
        bit [1:0] rd, wr;
        int w, bc;
        bit ob;
        rd = {m1_read, m0_read};
        wr = {m1_write, m0_write};
        ob = md_owner[0];
        bc = norm_bc(ob ? m1_burstcount : m0_burstcount);
        if (!reset_n) begin
            md_owner = -1; md_last = 1; md_cmd_done = 0; md_left = 0; md_first = 1;
        end else if (md_owner < 0) begin
            if ((rd | wr) != 2'b00) begin
                if ((rd[0] | wr[0]) && (rd[1] | wr[1])) w = (md_last == 0) ? 1 : 0;
                else w = (rd[0] | wr[0]) ? 0 : 1;
                md_owner = w; md_last = w; md_rd = rd[w]; md_cmd_done = 0; md_first = 1;
            end
        end else if (md_rd && !md_cmd_done) begin
            if (rd[ob] && !s_waitrequest) begin
                md_cmd_done = 1; md_left = bc;
            end
        end else if (md_rd) begin
            if (s_readdatavalid) begin
                md_left--;
                if (md_left == 0) md_owner = -1;
            end
        end else begin
            if (wr[ob] && !s_waitrequest) begin
                if (md_first) begin md_left = bc; md_first = 0; end
                md_left--;
                if (md_left == 0) md_owner = -1;
            end
        end
    end

    // Cycle compare of every output against the model
    always @(negedge clk) begin
        bit [1:0] rd, wr;
        bit ob, dp, has;
        logic [1:0] eg;
        if (chk_en) begin
            rd  = {m1_read, m0_read};
            wr  = {m1_write, m0_write};
            has = (md_owner >= 0);
            ob  = md_owner[0];
            dp  = has && md_rd && md_cmd_done;
            eg  = !has ? 2'b00 : (ob ? 2'b10 : 2'b01);
            chk("grant", grant, eg);
            chk("s_read", s_read, has && md_rd && !md_cmd_done && rd[ob]);
            chk("s_write", s_write, has && !md_rd && wr[ob]);
            chk("m0_waitrequest", m0_waitrequest, (has && !ob && !dp) ? s_waitrequest : 1'b1);
            chk("m1_waitrequest", m1_waitrequest, (has && ob && !dp) ? s_waitrequest : 1'b1);
            chk("m0_readdatavalid", m0_readdatavalid, dp && !ob && s_readdatavalid);
            chk("m1_readdatavalid", m1_readdatavalid, dp && ob && s_readdatavalid);
            chk("err_stray", err_stray, s_readdatavalid && !dp);
            if (has) begin
                chk("s_address", s_address, ob ? m1_address : m0_address);
                chk("s_burstcount", s_burstcount, ob ? m1_burstcount : m0_burstcount);
                chk("s_writedata", s_writedata, ob ? m1_writedata : m0_writedata);
                chk("s_byteenable", s_byteenable, ob ? m1_byteenable : m0_byteenable);
            end
            if (dp && s_readdatavalid)
                chk("readdata", ob ? m1_readdata : m0_readdata, s_readdata);
            cnt_rdv0   += int'(m0_readdatavalid);
            cnt_rdv1   += int'(m1_readdatavalid);
            cnt_err    += int'(err_stray);
            cnt_wr_acc += int'(s_write && !s_waitrequest);
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic beats(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            s_readdatavalid = 1'b1;
            s_readdata = base + 32'(i);
            tick();
        end
        s_readdatavalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, be, bw;
        reset_n = 0;
        m0_address = 0; m0_burstcount = 0; m0_writedata = 0; m0_byteenable = 4'hF;
        m1_address = 0; m1_burstcount = 0; m1_writedata = 0; m1_byteenable = 4'h3;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        s_waitrequest = 0; s_readdata = 0; s_readdatavalid = 0;
        tick();
        tick();
        chk_en = 1;
        reset_n = 1;
        #1;
        chk("rst grant", grant, 2'b00);
        chk("rst s_read", s_read, 1'b0);
        chk("rst s_write", s_write, 1'b0);
        chk("rst m0_wait", m0_waitrequest, 1'b1);
        chk("rst m1_wait", m1_waitrequest, 1'b1);
        chk("rst m0_rdv", m0_readdatavalid, 1'b0);
        chk("rst err", err_stray, 1'b0);

        // Single 16-beat read by m0
        m0_address = 32'h40; m0_burstcount = 6'd16; m0_read = 1;
        tick();
        chk("rd16 grant", grant, 2'b01);
        chk("rd16 s_read", s_read, 1'b1);
        chk("rd16 s_address", s_address, 32'h40);
        tick();
        m0_read = 0;
        beats(16, 32'h1000);
        chk("rd16 grant idle", grant, 2'b00);
        chk("rd16 m0 beats", cnt_rdv0, 16);
        chk("rd16 m1 beats", cnt_rdv1, 0);

        // Contention from reset: m0 read, m1 write
        do_reset();
        m0_address = 32'h100; m0_burstcount = 6'd2; m0_read = 1;
        m1_address = 32'h200; m1_burstcount = 6'd4; m1_write = 1; m1_writedata = 32'hA0;
        tick();
        chk("cont first grant", grant, 2'b01);
        tick();
        m0_read = 0;
        beats(2, 32'h2000);
        chk("cont idle gap", grant, 2'b00);
        tick();
        chk("cont second grant", grant, 2'b10);
        m0_address = 32'h140; m0_read = 1;
        for (int i = 0; i < 4; i++) begin
            m1_writedata = 32'hA0 + 32'(i);
            tick();
        end
        chk("cont wr done", grant, 2'b00);
        tick();
        chk("cont third grant", grant, 2'b01);
        m1_write = 0;
        tick();
        m0_read = 0;
        beats(2, 32'h3000);
        chk("cont final idle", grant, 2'b00);

        // m1 write burst with three stalled cycles
        m1_address = 32'h300; m1_burstcount = 6'd4; m1_write = 1; s_waitrequest = 1;
        tick();
        chk("stall grant", grant, 2'b10);
        for (int i = 0; i < 3; i++) begin
            chk("stall m1_wait", m1_waitrequest, 1'b1);
            tick();
        end
        s_waitrequest = 0;
        #1;
        chk("stall release", m1_waitrequest, 1'b0);
        bw = cnt_wr_acc;
        for (int i = 0; i < 4; i++) begin
            m1_writedata = 32'hB0 + 32'(i);
            tick();
        end
        m1_write = 0;
        #1;
        chk("stall beats", cnt_wr_acc - bw, 4);
        chk("stall wait after", m1_waitrequest, 1'b1);

        // Stray beat while idle
        tick();
        be = cnt_err;
        s_readdatavalid = 1; s_readdata = 32'hDEAD;
        #1;
        chk("stray err", err_stray, 1'b1);
        chk("stray m0_rdv", m0_readdatavalid, 1'b0);
        chk("stray m1_rdv", m1_readdatavalid, 1'b0);
        tick();
        s_readdatavalid = 0;
        #1;
        chk("stray err clear", err_stray, 1'b0);
        chk("stray pulse count", cnt_err - be, 1);

        // Reset after 5 of 16 read beats
        tick();
        m0_address = 32'h500; m0_burstcount = 6'd16; m0_read = 1;
        tick();
        chk("rstmid grant", grant, 2'b01);
        tick();
        m0_read = 0;
        beats(5, 32'h5000);
        b0 = cnt_rdv0;
        be = cnt_err;
        reset_n = 0;
        tick();
        reset_n = 1;
        #1;
        chk("rstmid grant idle", grant, 2'b00);
        chk("rstmid m0_wait", m0_waitrequest, 1'b1);
        beats(11, 32'h5005);
        chk("rstmid stray count", cnt_err - be, 11);
        chk("rstmid no delivery", cnt_rdv0 - b0, 0);
        m0_address = 32'h540; m0_burstcount = 6'd2; m0_read = 1;
        tick();
        chk("rstmid regrant", grant, 2'b01);
        tick();
        m0_read = 0;
        beats(2, 32'h5400);
        chk("rstmid read ok", cnt_rdv0 - b0, 2);
        chk("rstmid idle", grant, 2'b00);

        // Burstcount 0 read behaves as a single beat
        m0_address = 32'h600; m0_burstcount = 6'd0; m0_read = 1;
        b0 = cnt_rdv0;
        b1 = cnt_rdv1;
        tick();
        chk("bc0 grant", grant, 2'b01);
        tick();
        m0_read = 0;
        beats(1, 32'h6000);
        chk("bc0 idle", grant, 2'b00);
        chk("bc0 beats", cnt_rdv0 - b0, 1);
        chk("bc0 m1 beats", cnt_rdv1 - b1, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_arbiter.md
AVALON_ARBITER -- requirements
Module: avalon_arbiter

Interface
REQ-001 Parameter AW, default 32, Avalon byte-address width.
REQ-002 Parameter DW, default 32, Avalon data width; byteenable width is DW/8.
REQ-003 Parameter BW, default 6, burstcount width.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 mK_address / mK_burstcount / mK_writedata / mK_byteenable  in  AW/BW/DW/DW/8  requester K command fields (K = 0 video reader, 1 auxiliary master).
REQ-007 mK_read, mK_write  in  1 each  requester K command strobes.
REQ-008 mK_waitrequest  out  1  stall to requester K.
REQ-009 mK_readdata / mK_readdatavalid  out  DW/1  read return to requester K.
REQ-010 s_address, s_burstcount, s_writedata, s_byteenable, s_read, s_write  out  AW/BW/DW/DW/8/1/1  shared SDRAM host port.
REQ-011 s_waitrequest, s_readdata, s_readdatavalid  in  1/DW/1  SDRAM responses.
REQ-012 grant  out  2  one-hot current owner; 2'b00 when idle.
REQ-013 err_stray  out  1  one-cycle pulse on s_readdatavalid with no read pending.

Function
REQ-014 FSM states: IDLE, RD_CMD, RD_DATA, WR_BURST.
REQ-015 IDLE: a requester is pending when mK_read or mK_write is high; the winner is registered, so grant and the FSM update 1 cycle after the request is first seen.
REQ-016 Arbitration is round-robin: on contention, the requester not granted last wins; after reset, requester 0 wins first.
REQ-017 Owner read → RD_CMD; owner write → WR_BURST; read and write both high from the same requester → read wins.
REQ-018 Owner command fields and strobes pass combinationally to s_*; the non-owner sees mK_waitrequest=1; s_read=s_write=0 when grant=00.
REQ-019 Owner mK_waitrequest = s_waitrequest.
REQ-020 RD_CMD: on s_read && !s_waitrequest, latch beats = burstcount (0 is treated as 1) and go to RD_DATA; s_read is forced 0 in RD_DATA.
REQ-021 RD_DATA: route s_readdata/s_readdatavalid to the owner only and count beats; on the last beat, go to IDLE in the same cycle.
REQ-022 WR_BURST: count accepted beats (s_write && !s_waitrequest), latching burstcount on the first accepted beat; after the last beat go to IDLE; owner waitrequest is forced 1 once the count is reached.
REQ-023 One transaction is in flight at a time; no command is issued while in RD_DATA.
REQ-024 Grant release: the next grant may be issued 1 cycle after returning to IDLE (one idle cycle between transactions).
REQ-025 s_readdatavalid in IDLE, RD_CMD or WR_BURST: not routed; err_stray pulses.
REQ-026 Beat counter width is BW; no wrap occurs because the maximum count is 2^(BW-1).

Reset
REQ-027 When reset_n=0 at a clk edge:
- FSM = IDLE, grant = 00, beat counter = 0, round-robin pointer favours requester 0.
- Outputs the following cycle: s_read=0, s_write=0, both mK_waitrequest=1, mK_readdatavalid=0, err_stray=0.
REQ-028 Reset mid-burst abandons the transaction with no completion; beats arriving after reset raise err_stray.

Structure
REQ-029 Package avalon_arb_pkg holds the FSM state enum, requester index constants and default width constants.
REQ-030 Round-robin selection is a sub-module rr_arbiter2 (req[1:0], last, grant_next); everything else is in avalon_arbiter.

Verification
REQ-031 Single read: m0 read, addr 0x40, burst 16 → one cycle later grant=01 and s_read=1; 16 s_readdatavalid beats reach m0 only; then grant=00.
REQ-032 Contention: m0 read and m1 write (burst 4) asserted together from reset → m0 served first; m1 granted after the idle cycle; then with both requesting, m0 is served next.
REQ-033 Write stall: m1 write burst 4 with s_waitrequest high for 3 cycles → m1 waitrequest mirrors it; exactly 4 accepted beats; m1 waitrequest=1 after the 4th.
REQ-034 Stray beat: s_readdatavalid in IDLE → err_stray=1 for one cycle; m0/m1 readdatavalid stay 0.
REQ-035 Reset mid-read: reset_n low after 5 of 16 beats → next cycle grant=00 and state IDLE; the remaining beats pulse err_stray; the next m0 read proceeds normally.
REQ-036 Burstcount 0 read → treated as 1 beat; return to IDLE after the single readdatavalid.
